// File: rtl/game_ctrl_pkg.sv
// Shared encodings and defaults for the Pong game sequencer and text generator.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'b00,
    ST_NEWGAME = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } game_state_e;

  localparam int BALLS_DEFAULT      = 3;
  localparam int WAIT_TICKS_DEFAULT = 120;
  localparam int TIMER_W            = 7;

endpackage

// File: rtl/game_ctrl_bcd2_counter.sv
// Two-digit BCD score counter, saturating at 99; clear beats increment.
module bcd2_counter
  import game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig0_q, dig0_d;
  logic       at_max;

  assign at_max = (dig1_q == 4'd9) && (dig0_q == 4'd9);

  always_comb begin
    dig1_d = dig1_q;
    dig0_d = dig0_q;
    if (clr) begin
      dig1_d = 4'd0;
      dig0_d = 4'd0;
    end else if (inc && !at_max) begin
      if (dig0_q == 4'd9) begin
        dig0_d = 4'd0;
        dig1_d = dig1_q + 4'd1;
      end else begin
        dig0_d = dig0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig1_q <= 4'd0;
      dig0_q <= 4'd0;
    end else begin
      dig1_q <= dig1_d;
      dig0_q <= dig0_d;
    end
  end

  assign dig1 = dig1_q;
  assign dig0 = dig0_q;

endmodule

// File: rtl/game_ctrl.sv
// Pong game sequencer: game FSM, ball count, wait timer and score for the display path.
//   state   | meaning
//   PLAY    | ball in motion, hit/miss events active
//   NEWGAME | waiting for button to start a game
//   NEWBALL | frozen between balls, wait then button
//   OVER    | game finished, wait then back to NEWGAME
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int BALLS      = BALLS_DEFAULT,
  parameter int WAIT_TICKS = WAIT_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn,
  input  logic       hit,
  input  logic       miss,
  output logic [1:0] state,
  output logic [1:0] ball,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       gra_still
);

  game_state_e        state_q, state_d;
  logic [1:0]         ball_q, ball_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               btn_q;
  logic               still_q, still_d;
  logic               btn_re;
  logic               timer_done;
  logic               score_clr;
  logic               score_inc;

  assign btn_re     = btn & ~btn_q;
  assign timer_done = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    ball_d    = ball_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      ST_NEWGAME: begin
        if (btn_re) begin
          state_d   = ST_PLAY;
          score_clr = 1'b1;
          ball_d    = 2'(BALLS);
        end
      end
      ST_PLAY: begin
        // A simultaneous hit is dropped so a lost ball never scores.
        if (miss) begin
          ball_d  = ball_q - 2'd1;
          state_d = (ball_q > 2'd1) ? ST_NEWBALL : ST_OVER;
        end else if (hit) begin
          score_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (timer_done && btn_re) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (timer_done) state_d = ST_NEWGAME;
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) && (state_d == ST_NEWBALL || state_d == ST_OVER)) begin
      timer_d = TIMER_W'(WAIT_TICKS);
    end else if (tick && !timer_done) begin
      timer_d = timer_q - 1'b1;
    end
  end

  assign still_d = (state_d != ST_PLAY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_NEWGAME;
      ball_q  <= 2'(BALLS);
      timer_q <= '0;
      btn_q   <= 1'b0;
      still_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ball_q  <= ball_d;
      timer_q <= timer_d;
      btn_q   <= btn;
      still_q <= still_d;
    end
  end

  bcd2_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .dig1  (dig1),
    .dig0  (dig0)
  );

  assign state     = state_q;
  assign ball      = ball_q;
  assign gra_still = still_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: walks a full game with hand-computed expectations.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, btn, hit, miss;
  logic [1:0] state, ball;
  logic [3:0] dig1, dig0;
  logic       gra_still;

  int n_chk = 0;
  int n_err = 0;

  game_ctrl #(.BALLS(3), .WAIT_TICKS(120)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .btn       (btn),
    .hit       (hit),
    .miss      (miss),
    .state     (state),
    .ball      (ball),
    .dig1      (dig1),
    .dig0      (dig0),
    .gra_still (gra_still)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cycle();
      tick = 1'b0; cycle();
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; cycle();
      hit = 1'b0; cycle();
    end
  endtask

  task automatic btn_pulse();
    btn = 1'b1; cycle();
    btn = 1'b0; cycle();
  endtask

  task automatic chk_all(input string tag, input int st, input int bl, input int score, input int still);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".ball"},  int'(ball),  bl);
    chk({tag, ".score"}, int'(dig1) * 10 + int'(dig0), score);
    chk({tag, ".still"}, int'(gra_still), still);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; btn = 1'b0; hit = 1'b0; miss = 1'b0;
    #2;
    cycle(); cycle();
    chk_all("rst", 1, 3, 0, 1);
    chk("rst.timer", int'(dut.timer_q), 0);
    reset = 1'b0;
    cycle(); cycle(); cycle();
    chk_all("idle", 1, 3, 0, 1);

    // Button held 5 cycles: one transition on first high sample.
    btn = 1'b1; cycle();
    chk_all("start", 0, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("start.hold", int'(state), 0);
    end
    btn = 1'b0; cycle();

    hits(12);
    chk_all("hit12", 0, 3, 12, 0);

    hit = 1'b1; miss = 1'b1; cycle();
    hit = 1'b0; miss = 1'b0;
    chk_all("hitmiss", 2, 2, 12, 1);
    chk("hitmiss.timer", int'(dut.timer_q), 120);
    cycle();

    // Hits outside PLAY are ignored.
    hits(2);
    chk("nb.hit_ign", int'(dig1) * 10 + int'(dig0), 12);

    ticks(119);
    chk("nb.timer119", int'(dut.timer_q), 1);
    btn_pulse();
    chk("nb.early_btn", int'(state), 2);
    ticks(1);
    chk("nb.timer0", int'(dut.timer_q), 0);
    btn = 1'b1; cycle();
    chk_all("nb.resume", 0, 2, 12, 0);
    btn = 1'b0; cycle();

    hits(8);
    chk("carry20", int'(dig1) * 10 + int'(dig0), 20);
    hits(79);
    chk("score99", int'(dig1) * 10 + int'(dig0), 99);
    hits(1);
    chk("sat99", int'(dig1) * 10 + int'(dig0), 99);

    miss = 1'b1; cycle(); miss = 1'b0;
    chk_all("miss2", 2, 1, 99, 1);
    ticks(120);
    btn_pulse();
    chk("resume2", int'(state), 0);

    miss = 1'b1; cycle(); miss = 1'b0;
    chk_all("over", 3, 0, 99, 1);
    ticks(119);
    chk("over.119", int'(state), 3);
    tick = 1'b1; cycle(); tick = 1'b0;
    chk("over.120", int'(state), 3);
    cycle();
    chk_all("newgame", 1, 0, 99, 1);
    cycle();
    btn = 1'b1; cycle(); btn = 1'b0;
    chk_all("restart", 0, 3, 0, 0);
    cycle();

    hits(1);
    miss = 1'b1; cycle(); miss = 1'b0;
    chk_all("nb2", 2, 2, 1, 1);
    ticks(70);
    chk("nb2.timer50", int'(dut.timer_q), 50);
    reset = 1'b1; tick = 1'b1; btn = 1'b1; cycle();
    reset = 1'b0; tick = 1'b0; btn = 1'b0;
    chk_all("midrst", 1, 3, 0, 1);
    chk("midrst.timer", int'(dut.timer_q), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
